memory_interface_arbiter: RTL

Shares one single-ported memory bus between the core's instruction and data memory interfaces. Sits between `phoeniX` and the system memory. Serialises requests with data-priority arbitration, anti-starvation for fetches, per-access timeout, and a one-cycle `ready` pulse back to the requester that was served.

---
 rtl/memory_interface_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/memory_interface_arbiter.sv
// Arbitrates one single-ported memory bus between the instruction and data ports.
// Data wins ties unless fetches have been starved; accesses can abort on timeout.
module memory_interface_arbiter #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int STARVATION_LIMIT = 4,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instruction_memory_interface_enable,
  input  logic                     instruction_memory_interface_state,
  input  logic [ADDRESS_WIDTH-1:0] instruction_memory_interface_address,
  input  logic [3:0]               instruction_memory_interface_frame_mask,
  output logic [31:0]              instruction_memory_interface_read_data,
  output logic                     instruction_memory_interface_ready,
  input  logic                     data_memory_interface_enable,
  input  logic                     data_memory_interface_state,
  input  logic [ADDRESS_WIDTH-1:0] data_memory_interface_address,
  input  logic [3:0]               data_memory_interface_frame_mask,
  input  logic [31:0]              data_memory_interface_write_data,
  output logic [31:0]              data_memory_interface_read_data,
  output logic                     data_memory_interface_ready,
  output logic                     memory_enable,
  output logic                     memory_state,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [3:0]               memory_frame_mask,
  output logic [31:0]              memory_write_data,
  input  logic [31:0]              memory_read_data,
  input  logic                     memory_ready,
  output logic                     memory_owner,
  output logic                     bus_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_t;

  state_t          r_state;
  logic [3:0]      r_starve;
  logic [TW-1:0]   r_tmo;

  logic            w_ien, w_den;
  logic            w_grant_d;
  logic            w_tmo_hit;
  logic [31:0]     w_rdata;

  assign w_ien     = instruction_memory_interface_enable;
  assign w_den     = data_memory_interface_enable;
  // Data takes the bus unless a pending fetch has already lost STARVATION_LIMIT times.
  assign w_grant_d = w_den & (~w_ien | (r_starve != 4'(STARVATION_LIMIT)));
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TW'(TIMEOUT_CYCLES));
  assign w_rdata   = memory_state ? 32'h0 : memory_read_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state                                <= IDLE;
      r_starve                               <= '0;
      r_tmo                                  <= '0;
      memory_enable                          <= 1'b0;
      memory_state                           <= 1'b0;
      memory_address                         <= '0;
      memory_frame_mask                      <= '0;
      memory_write_data                      <= '0;
      memory_owner                           <= 1'b0;
      bus_error                              <= 1'b0;
      instruction_memory_interface_read_data <= '0;
      instruction_memory_interface_ready     <= 1'b0;
      data_memory_interface_read_data        <= '0;
      data_memory_interface_ready            <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_den | w_ien) begin
            r_state       <= ACCESS;
            r_tmo         <= '0;
            memory_enable <= 1'b1;
            if (w_grant_d) begin
              memory_state      <= data_memory_interface_state;
              memory_address    <= data_memory_interface_address;
              memory_frame_mask <= data_memory_interface_frame_mask;
              memory_write_data <= data_memory_interface_write_data;
              memory_owner      <= 1'b1;
              r_starve          <= w_ien ? r_starve + 4'd1 : 4'd0;
            end else begin
              memory_state      <= instruction_memory_interface_state;
              memory_address    <= instruction_memory_interface_address;
              memory_frame_mask <= instruction_memory_interface_frame_mask;
              memory_write_data <= 32'h0;
              memory_owner      <= 1'b0;
              r_starve          <= 4'd0;
            end
          end
        end
        ACCESS: begin
          if (memory_ready || w_tmo_hit) begin
            r_state       <= RESPONSE;
            memory_enable <= 1'b0;
            bus_error     <= ~memory_ready;
            if (memory_owner) begin
              data_memory_interface_ready     <= 1'b1;
              data_memory_interface_read_data <= memory_ready ? w_rdata : 32'h0;
            end else begin
              instruction_memory_interface_ready     <= 1'b1;
              instruction_memory_interface_read_data <= memory_ready ? w_rdata : 32'h0;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        RESPONSE: begin
          r_state                            <= IDLE;
          r_tmo                              <= '0;
          bus_error                          <= 1'b0;
          instruction_memory_interface_ready <= 1'b0;
          data_memory_interface_ready        <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
